// File: rtl/count_event_monitor.sv
// Event monitor for a WIDTH-bit counter: compares each valid sample against a
// programmable value and reports match/wrap pulses, a PWM level and a saturating event count.
module count_event_monitor #(
  parameter int WIDTH = 5,
  parameter int EVT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cnt_valid,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic [WIDTH-1:0] cmp_val,
  input  logic             cmp_we,
  input  logic             oneshot,
  input  logic             clr,
  output logic             match_pulse,
  output logic             wrap_pulse,
  output logic             pwm_out,
  output logic [EVT_W-1:0] match_cnt,
  output logic             sticky_match,
  output logic [1:0]       state_o
);

  // cnt_valid qualifies cnt_in for one cycle; there is no back-pressure, so
  // every cycle with cnt_valid=1 is consumed as exactly one sample.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [EVT_W-1:0] CNT_MAX = '1;
  localparam logic [EVT_W-1:0] CNT_ONE = {{(EVT_W-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [WIDTH-1:0] cmp_reg;
  logic [WIDTH-1:0] cnt_q;
  logic             prev_vld;
  logic             m, w, report;

  // A count stalled at the compare value must not re-fire, hence the edge term.
  assign m = cnt_valid && (cnt_in == cmp_reg) && (!prev_vld || (cnt_in != cnt_q));
  assign w = cnt_valid && prev_vld && (cnt_q == '1) && (cnt_in == '0);

  always_comb begin
    state_nxt = state;
    report    = 1'b0;
    case (state)
      IDLE: begin
        if (cnt_valid) begin
          report    = m;
          state_nxt = (m && oneshot) ? HOLD : RUN;
        end
      end
      RUN: begin
        report = m;
        if (m && oneshot) state_nxt = HOLD;
      end
      HOLD: begin
        // clr releases HOLD and lets a coincident match through as in RUN.
        if (clr) begin
          report    = m;
          state_nxt = (m && oneshot) ? HOLD : RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cmp_reg      <= '0;
      cnt_q        <= '0;
      prev_vld     <= 1'b0;
      match_pulse  <= 1'b0;
      wrap_pulse   <= 1'b0;
      pwm_out      <= 1'b0;
      match_cnt    <= '0;
      sticky_match <= 1'b0;
    end else begin
      state       <= state_nxt;
      match_pulse <= report;
      wrap_pulse  <= w;
      if (cmp_we) cmp_reg <= cmp_val;
      if (cnt_valid) begin
        cnt_q    <= cnt_in;
        prev_vld <= 1'b1;
        pwm_out  <= (cnt_in < cmp_reg);
      end
      // A match coinciding with clr counts as the first event after the clear.
      if (clr) begin
        match_cnt    <= report ? CNT_ONE : '0;
        sticky_match <= report;
      end else if (report) begin
        if (match_cnt != CNT_MAX) match_cnt <= match_cnt + CNT_ONE;
        sticky_match <= 1'b1;
      end
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_count_event_monitor.sv
// Directed bench for count_event_monitor: each task drives one scenario and
// compares outputs one time unit after the sampling edge.
module tb_count_event_monitor;

  logic       clk;
  logic       reset;
  logic       cnt_valid;
  logic [4:0] cnt_in;
  logic [4:0] cmp_val;
  logic       cmp_we;
  logic       oneshot;
  logic       clr;
  logic       match_pulse;
  logic       wrap_pulse;
  logic       pwm_out;
  logic [3:0] match_cnt;
  logic       sticky_match;
  logic [1:0] state_o;

  int errors = 0;
  int checks = 0;

  count_event_monitor #(.WIDTH(5), .EVT_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .cnt_valid    (cnt_valid),
    .cnt_in       (cnt_in),
    .cmp_val      (cmp_val),
    .cmp_we       (cmp_we),
    .oneshot      (oneshot),
    .clr          (clr),
    .match_pulse  (match_pulse),
    .wrap_pulse   (wrap_pulse),
    .pwm_out      (pwm_out),
    .match_cnt    (match_cnt),
    .sticky_match (sticky_match),
    .state_o      (state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, simulation did not finish");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [4:0] v);
    cnt_valid = 1'b1;
    cnt_in    = v;
    tick();
    cnt_valid = 1'b0;
  endtask

  task automatic idle_tick();
    cnt_valid = 1'b0;
    tick();
  endtask

  task automatic load_cmp_clr(input logic [4:0] v);
    cmp_val = v;
    cmp_we  = 1'b1;
    clr     = 1'b1;
    idle_tick();
    cmp_we  = 1'b0;
    clr     = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0; cnt_valid = 1'b0; cnt_in = '0; cmp_val = '0;
    cmp_we = 1'b0; oneshot = 1'b0; clr = 1'b0;
    #23;
    checks++;
    if ({match_pulse, wrap_pulse, pwm_out, match_cnt, sticky_match, state_o} !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs: got mp=%b wp=%b pwm=%b cnt=%0d st=%b state=%0d, expected all 0",
               match_pulse, wrap_pulse, pwm_out, match_cnt, sticky_match, state_o);
    end
    reset = 1'b1;
    idle_tick();
    checks++;
    if (state_o !== 2'd0) begin
      errors++;
      $display("FAIL reset_idle_hold: state=%0d expected 0", state_o);
    end
  endtask

  task automatic test_count_period();
    cmp_val = 5'd5; cmp_we = 1'b1;
    idle_tick();
    cmp_we = 1'b0;
    for (int i = 0; i < 33; i++) begin
      logic [4:0] v;
      logic exp_m, exp_w, exp_p;
      v     = 5'(i % 32);
      exp_m = (i == 5);
      exp_w = (i == 32);
      exp_p = (v < 5'd5);
      sample(v);
      checks++;
      if (match_pulse !== exp_m) begin
        errors++;
        $display("FAIL period_match[%0d]: got %b expected %b", i, match_pulse, exp_m);
      end
      checks++;
      if (wrap_pulse !== exp_w) begin
        errors++;
        $display("FAIL period_wrap[%0d]: got %b expected %b", i, wrap_pulse, exp_w);
      end
      checks++;
      if (pwm_out !== exp_p) begin
        errors++;
        $display("FAIL period_pwm[%0d]: got %b expected %b", i, pwm_out, exp_p);
      end
    end
    checks++;
    if (match_cnt !== 4'd1 || sticky_match !== 1'b1 || state_o !== 2'd1) begin
      errors++;
      $display("FAIL period_end: cnt=%0d st=%b state=%0d expected cnt=1 st=1 state=1",
               match_cnt, sticky_match, state_o);
    end
  endtask

  task automatic test_stall();
    clr = 1'b1;
    idle_tick();
    clr = 1'b0;
    checks++;
    if (match_cnt !== 4'd0 || sticky_match !== 1'b0) begin
      errors++;
      $display("FAIL clr_no_match: cnt=%0d st=%b expected cnt=0 st=0", match_cnt, sticky_match);
    end
    for (int i = 0; i < 8; i++) begin
      logic [4:0] v;
      logic exp_m;
      v     = (i < 4) ? 5'(i + 1) : 5'd5;
      exp_m = (i == 4);
      sample(v);
      checks++;
      if (match_pulse !== exp_m) begin
        errors++;
        $display("FAIL stall_match[%0d]: got %b expected %b", i, match_pulse, exp_m);
      end
    end
    checks++;
    if (match_cnt !== 4'd1) begin
      errors++;
      $display("FAIL stall_count: got %0d expected 1", match_cnt);
    end
  endtask

  task automatic test_oneshot();
    load_cmp_clr(5'd3);
    oneshot = 1'b1;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 32; i++) begin
        logic exp_m, exp_w, exp_p;
        logic [1:0] exp_s;
        exp_m = (p == 0 && i == 3);
        exp_w = (p == 1 && i == 0);
        exp_p = (i < 3);
        exp_s = (p == 0 && i < 3) ? 2'd1 : 2'd2;
        sample(5'(i));
        checks++;
        if (match_pulse !== exp_m || wrap_pulse !== exp_w || pwm_out !== exp_p || state_o !== exp_s) begin
          errors++;
          $display("FAIL oneshot[%0d.%0d]: mp=%b wp=%b pwm=%b state=%0d expected mp=%b wp=%b pwm=%b state=%0d",
                   p, i, match_pulse, wrap_pulse, pwm_out, state_o, exp_m, exp_w, exp_p, exp_s);
        end
      end
    end
    checks++;
    if (match_cnt !== 4'd1 || sticky_match !== 1'b1) begin
      errors++;
      $display("FAIL oneshot_frozen: cnt=%0d st=%b expected cnt=1 st=1", match_cnt, sticky_match);
    end
    oneshot = 1'b0;
    sample(5'd0);
    sample(5'd3);
    checks++;
    if (match_pulse !== 1'b0 || state_o !== 2'd2) begin
      errors++;
      $display("FAIL hold_ignores_oneshot: mp=%b state=%0d expected mp=0 state=2", match_pulse, state_o);
    end
    clr = 1'b1;
    idle_tick();
    clr = 1'b0;
    checks++;
    if (state_o !== 2'd1 || match_cnt !== 4'd0) begin
      errors++;
      $display("FAIL oneshot_release: state=%0d cnt=%0d expected state=1 cnt=0", state_o, match_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      sample(5'(i));
      checks++;
      if (match_pulse !== (i == 3)) begin
        errors++;
        $display("FAIL rearm_match[%0d]: got %b expected %b", i, match_pulse, (i == 3));
      end
    end
    checks++;
    if (match_cnt !== 4'd1 || state_o !== 2'd1) begin
      errors++;
      $display("FAIL rearm_end: cnt=%0d state=%0d expected cnt=1 state=1", match_cnt, state_o);
    end
  endtask

  task automatic test_saturate();
    load_cmp_clr(5'd3);
    for (int k = 1; k <= 20; k++) begin
      logic [3:0] exp_c;
      exp_c = (k < 15) ? 4'(k) : 4'd15;
      sample(5'd4);
      sample(5'd3);
      checks++;
      if (match_pulse !== 1'b1 || match_cnt !== exp_c) begin
        errors++;
        $display("FAIL saturate[%0d]: mp=%b cnt=%0d expected mp=1 cnt=%0d", k, match_pulse, match_cnt, exp_c);
      end
    end
    checks++;
    if (sticky_match !== 1'b1) begin
      errors++;
      $display("FAIL saturate_sticky: got %b expected 1", sticky_match);
    end
  endtask

  task automatic test_clr_same_cycle();
    sample(5'd4);
    clr = 1'b1;
    sample(5'd3);
    clr = 1'b0;
    checks++;
    if (match_pulse !== 1'b1 || match_cnt !== 4'd1 || sticky_match !== 1'b1) begin
      errors++;
      $display("FAIL clr_match_run: mp=%b cnt=%0d st=%b expected mp=1 cnt=1 st=1",
               match_pulse, match_cnt, sticky_match);
    end
    oneshot = 1'b1;
    sample(5'd4);
    sample(5'd3);
    checks++;
    if (match_cnt !== 4'd2 || state_o !== 2'd2) begin
      errors++;
      $display("FAIL enter_hold: cnt=%0d state=%0d expected cnt=2 state=2", match_cnt, state_o);
    end
    sample(5'd4);
    sample(5'd3);
    checks++;
    if (match_pulse !== 1'b0 || match_cnt !== 4'd2) begin
      errors++;
      $display("FAIL hold_suppress: mp=%b cnt=%0d expected mp=0 cnt=2", match_pulse, match_cnt);
    end
    sample(5'd4);
    clr = 1'b1;
    sample(5'd3);
    clr = 1'b0;
    checks++;
    if (match_pulse !== 1'b1 || match_cnt !== 4'd1 || sticky_match !== 1'b1 || state_o !== 2'd2) begin
      errors++;
      $display("FAIL clr_match_hold: mp=%b cnt=%0d st=%b state=%0d expected mp=1 cnt=1 st=1 state=2",
               match_pulse, match_cnt, sticky_match, state_o);
    end
    oneshot = 1'b0;
  endtask

  task automatic test_no_wrap_on_load();
    load_cmp_clr(5'd20);
    sample(5'd10);
    sample(5'd0);
    checks++;
    if (wrap_pulse !== 1'b0 || pwm_out !== 1'b1) begin
      errors++;
      $display("FAIL load_no_wrap: wp=%b pwm=%b expected wp=0 pwm=1", wrap_pulse, pwm_out);
    end
    sample(5'd31);
    checks++;
    if (wrap_pulse !== 1'b0 || pwm_out !== 1'b0) begin
      errors++;
      $display("FAIL at_31: wp=%b pwm=%b expected wp=0 pwm=0", wrap_pulse, pwm_out);
    end
    sample(5'd0);
    checks++;
    if (wrap_pulse !== 1'b1) begin
      errors++;
      $display("FAIL real_wrap: got %b expected 1", wrap_pulse);
    end
    idle_tick();
    checks++;
    if (wrap_pulse !== 1'b0 || pwm_out !== 1'b1) begin
      errors++;
      $display("FAIL invalid_hold: wp=%b pwm=%b expected wp=0 pwm=1", wrap_pulse, pwm_out);
    end
  endtask

  task automatic test_async_reset();
    cmp_val = 5'd2; cmp_we = 1'b1;
    idle_tick();
    cmp_we = 1'b0;
    sample(5'd0);
    sample(5'd1);
    sample(5'd2);
    checks++;
    if (match_pulse !== 1'b1 || state_o !== 2'd1) begin
      errors++;
      $display("FAIL pre_reset_match: mp=%b state=%0d expected mp=1 state=1", match_pulse, state_o);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({match_pulse, wrap_pulse, pwm_out, match_cnt, sticky_match, state_o} !== 10'd0) begin
      errors++;
      $display("FAIL async_reset: mp=%b wp=%b pwm=%b cnt=%0d st=%b state=%0d expected all 0",
               match_pulse, wrap_pulse, pwm_out, match_cnt, sticky_match, state_o);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    idle_tick();
    checks++;
    if (state_o !== 2'd0) begin
      errors++;
      $display("FAIL post_reset_idle: state=%0d expected 0", state_o);
    end
    sample(5'd0);
    checks++;
    if (match_pulse !== 1'b1 || state_o !== 2'd1 || pwm_out !== 1'b0 || match_cnt !== 4'd1) begin
      errors++;
      $display("FAIL post_reset_first: mp=%b state=%0d pwm=%b cnt=%0d expected mp=1 state=1 pwm=0 cnt=1",
               match_pulse, state_o, pwm_out, match_cnt);
    end
    sample(5'd0);
    checks++;
    if (match_pulse !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_stall: got %b expected 0", match_pulse);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_count_period();
    test_stall();
    test_oneshot();
    test_saturate();
    test_clr_same_cycle();
    test_no_wrap_on_load();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/count_event_monitor.md
Name: count_event_monitor

Overview:
Downstream consumer of the generic 5-bit loadable counter. Samples the counter's output on every enabled cycle and compares it against a programmable value. Produces a one-cycle match pulse, a wrap pulse, a PWM level, a saturating match-event count and a sticky flag. Supports a one-shot mode that freezes event reporting after the first match until software clears it.

Parameters:
WIDTH, 5, width of the sampled count and compare value
EVT_W, 4, width of the saturating match-event counter

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous active-low reset (0 = reset asserted)
cnt_valid  input  1  high when cnt_in is to be sampled this cycle (driven with the counter's enb)
cnt_in  input  WIDTH  counter value (the counter's cnt_out)
cmp_val  input  WIDTH  new compare value
cmp_we  input  1  load cmp_val into the compare register
oneshot  input  1  1 = freeze after the first match (HOLD); 0 = free-running
clr  input  1  clear match_cnt and sticky_match, release HOLD
match_pulse  output  1  one-cycle pulse on a new match
wrap_pulse  output  1  one-cycle pulse on an all-ones to zero transition
pwm_out  output  1  1 while the sampled count < compare register
match_cnt  output  EVT_W  saturating number of matches
sticky_match  output  1  set on match, cleared by clr
state_o  output  2  FSM state: 0 IDLE, 1 RUN, 2 HOLD

Behaviour:
- Reset (reset=0, async) forces the following; all outputs are registered:
  - cmp_reg=0, cnt_q=0, prev_vld=0.
  - match_pulse=0, wrap_pulse=0, pwm_out=0, match_cnt=0, sticky_match=0, state=IDLE.
- Compare register: cmp_reg<=cmp_val when cmp_we=1. A same-cycle comparison uses the old cmp_reg.
- Sampling: on cnt_valid=1, cnt_q<=cnt_in and prev_vld<=1. On cnt_valid=0 everything holds and pulses drop to 0.
- Match condition m:
  - cnt_valid=1, cnt_in==cmp_reg, and (prev_vld=0 or cnt_in!=cnt_q).
  - A count stalled at the compare value fires only once.
- Wrap condition w: cnt_valid=1, prev_vld=1, cnt_q=all-ones and cnt_in=0. A load that jumps to 0 from a non-all-ones value is not a wrap.
- Latency: match_pulse and wrap_pulse are high exactly one cycle, in the cycle after the sampling edge. They are never stretched.
- pwm_out: on each valid sample, pwm_out<=(cnt_in<cmp_reg), unsigned; otherwise it holds. With cmp_reg=0, pwm_out stays 0.
- FSM:
  - IDLE -> RUN on the first cnt_valid. That sample is evaluated for m (prev_vld=0, so no edge requirement).
  - RUN: on m, pulse, update match_cnt and sticky. If oneshot=1, go to HOLD.
  - HOLD: match_pulse suppressed, match_cnt and sticky_match frozen. wrap_pulse and pwm_out keep operating. clr=1 -> RUN.
  - In HOLD, a match in the same cycle as clr is reported and handled as in RUN.
- match_cnt saturates at 2^EVT_W-1 and never wraps.
- clr in the same cycle as a reported match: match_cnt=1 and sticky_match=1. The event is never lost.
- clr without a match: match_cnt=0, sticky_match=0.
- oneshot is sampled only at the RUN->HOLD decision. Changing it while in HOLD has no effect until clr.
- Reset mid-operation: every register returns to its reset value immediately. The first sample after release re-enters RUN with no edge requirement.

Test Plan:
- Reset=0 then release; load cmp=5 (cmp_we). Count 0..31 with cnt_valid=1, oneshot=0:
  - match_pulse exactly one cycle after the sample of 5.
  - wrap_pulse one cycle after 31->0.
  - pwm_out=1 for samples 0-4 and 0 for samples 5-31.
- Stall the counter at 5 (cnt_valid=1, cnt_in=5 for 4 cycles) -> a single match_pulse, match_cnt=1.
- oneshot=1, cmp=3, count through two full periods:
  - State goes RUN->HOLD after the first 3; one match_pulse total, match_cnt=1.
  - wrap_pulse still fires.
  - clr -> state RUN; the next 3 pulses again.
- 20 matches with oneshot=0, EVT_W=4 -> match_cnt saturates at 15, sticky_match=1.
- clr asserted in the same cycle as a matching sample -> match_cnt=1, sticky_match=1.
- Counter loaded 10 -> 0 (no wrap) -> wrap_pulse stays 0.
- Assert reset=0 asynchronously mid-count -> all outputs 0 and state_o=0 before the next clk edge. After release, the first valid sample equal to cmp_reg pulses.
